// File: rtl/mux_nto1_reg_scan_if.sv
// Bus bundle for the registered N-to-1 scan multiplexer.
// The master side drives channel data, select, mode, enable and mask.
// The slave side (the mux) returns the registered selection and its status.
interface mux_nto1_reg_scan_if #(
   parameter int WIDTH  = 16,
   parameter int NUM_IN = 8,
   parameter int SEL_W  = 3
);
   logic [NUM_IN*WIDTH-1:0] I;
   logic [SEL_W-1:0]        S;
   logic                    MODE;
   logic                    EN;
   logic [NUM_IN-1:0]       MASK;
   logic [WIDTH-1:0]        Y;
   logic [SEL_W-1:0]        CH;
   logic                    VALID;
   logic                    ERR;

   modport master (
      output I, S, MODE, EN, MASK,
      input  Y, CH, VALID, ERR
   );

   modport slave (
      input  I, S, MODE, EN, MASK,
      output Y, CH, VALID, ERR
   );
endinterface

// File: rtl/mux_nto1_reg_scan.sv
// Registered N-to-1 datapath multiplexer with clock enable.
// MODE=0 picks the channel named by S (out-of-range selects raise ERR).
// MODE=1 walks round-robin through the channels enabled in MASK, starting
// from the retained scan pointer, one channel per enabled cycle.
// All outputs come straight from flops, so there is no input-to-output path.
module mux_nto1_reg_scan #(
   parameter int WIDTH  = 16,
   parameter int NUM_IN = 8,
   parameter int SEL_W  = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   mux_nto1_reg_scan_if.slave   bus
);

   // NUM_IN expressed one bit wider than an index, so range checks and
   // wrap comparisons never overflow even when NUM_IN is a power of two.
   localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

   logic [WIDTH-1:0]  y_q,     y_d;
   logic [SEL_W-1:0]  ch_q,    ch_d;
   logic              valid_q, valid_d;
   logic              err_q,   err_d;
   logic [SEL_W-1:0]  p_q,     p_d;

   logic [NUM_IN-1:0] rotMask;
   logic              found;
   logic [SEL_W-1:0]  kOff;
   logic [SEL_W:0]    kSum;
   logic [SEL_W-1:0]  kIdx;
   logic [SEL_W:0]    pInc;
   logic [SEL_W-1:0]  pNext;
   logic              sInRange;
   logic [SEL_W-1:0]  selIdx;
   logic [WIDTH-1:0]  selData;

   // Rotate the mask so bit 0 is the channel at the scan pointer, then take
   // the lowest set bit and map it back to an absolute channel index.
   always_comb begin
      rotMask = '0;
      for (int j = 0; j < NUM_IN; j++) begin
         if (int'(p_q) + j >= NUM_IN) begin
            rotMask[j] = bus.MASK[int'(p_q) + j - NUM_IN];
         end else begin
            rotMask[j] = bus.MASK[int'(p_q) + j];
         end
      end

      found = 1'b0;
      kOff  = '0;
      for (int j = NUM_IN - 1; j >= 0; j--) begin
         if (rotMask[j]) begin
            found = 1'b1;
            kOff  = SEL_W'(j);
         end
      end

      kSum = {1'b0, p_q} + {1'b0, kOff};
      if (kSum >= NUM_IN_W) begin
         kIdx = SEL_W'(kSum - NUM_IN_W);
      end else begin
         kIdx = SEL_W'(kSum);
      end

      pInc = {1'b0, kIdx} + 1'b1;
      if (pInc == NUM_IN_W) begin
         pNext = '0;
      end else begin
         pNext = SEL_W'(pInc);
      end
   end

   // Pick the channel data for whichever index the current mode selects;
   // the compare-per-channel form never indexes outside the packed bus.
   always_comb begin
      sInRange = ({1'b0, bus.S} < NUM_IN_W);
      selIdx   = bus.MODE ? kIdx : bus.S;
      selData  = '0;
      for (int c = 0; c < NUM_IN; c++) begin
         if (SEL_W'(c) == selIdx) begin
            selData = bus.I[c*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state for every register; with EN low everything simply holds.
   always_comb begin
      y_d     = y_q;
      ch_d    = ch_q;
      valid_d = valid_q;
      err_d   = err_q;
      p_d     = p_q;
      if (bus.EN) begin
         if (!bus.MODE) begin
            ch_d = bus.S;
            if (sInRange) begin
               y_d     = selData;
               valid_d = 1'b1;
               err_d   = 1'b0;
            end else begin
               y_d     = '0;
               valid_d = 1'b0;
               err_d   = 1'b1;
            end
         end else begin
            err_d = 1'b0;
            if (found) begin
               y_d     = selData;
               ch_d    = kIdx;
               valid_d = 1'b1;
               p_d     = pNext;
            end else begin
               valid_d = 1'b0;
            end
         end
      end
   end

   // All state lives here; reset wins over enable and mode.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         y_q     <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         p_q     <= '0;
      end else begin
         y_q     <= y_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         p_q     <= p_d;
      end
   end

   assign bus.Y     = y_q;
   assign bus.CH    = ch_q;
   assign bus.VALID = valid_q;
   assign bus.ERR   = err_q;

endmodule

// File: tb/tb_mux_nto1_reg_scan.sv
// Directed bench for mux_nto1_reg_scan: an 8x16 instance (defaults) and a
// 5x8 instance for the non-power-of-two case. Each step pushes the model's
// expected registered outputs onto a queue, and the next edge pops them.
module tb_mux_nto1_reg_scan;

   logic clk;
   logic rstA;
   logic rstB;

   mux_nto1_reg_scan_if #(.WIDTH(16), .NUM_IN(8), .SEL_W(3)) busA ();
   mux_nto1_reg_scan_if #(.WIDTH(8),  .NUM_IN(5), .SEL_W(3)) busB ();

   mux_nto1_reg_scan #(.WIDTH(16), .NUM_IN(8), .SEL_W(3)) dutA (
      .clk_i (clk),
      .rst_i (rstA),
      .bus   (busA)
   );

   mux_nto1_reg_scan #(.WIDTH(8), .NUM_IN(5), .SEL_W(3)) dutB (
      .clk_i (clk),
      .rst_i (rstB),
      .bus   (busB)
   );

   typedef struct {
      int          dut;
      logic [15:0] y;
      logic [2:0]  ch;
      logic        valid;
      logic        err;
      string       tag;
   } expect_t;

   expect_t     sb[$];
   int          checks = 0;
   int          errors = 0;

   logic [15:0] chanA [8];
   logic [7:0]  chanB [5];

   // Reference state per instance: 0 = 8-channel, 1 = 5-channel.
   int mY  [2];
   int mCh [2];
   int mV  [2];
   int mE  [2];
   int mP  [2];

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int chanVal(input int d, input int idx);
      if (d == 0) return int'(chanA[idx]);
      return int'(chanB[idx]);
   endfunction

   // Behavioural model: linear search from the pointer, modulo channel count.
   task automatic modelStep(input int d, input logic rst, input logic en,
                            input logic mode, input logic [2:0] s,
                            input logic [7:0] mask);
      int n;
      int idx;
      bit hit;
      n = (d == 0) ? 8 : 5;
      if (rst) begin
         mY[d] = 0; mCh[d] = 0; mV[d] = 0; mE[d] = 0; mP[d] = 0;
      end else if (en) begin
         if (!mode) begin
            mCh[d] = int'(s);
            if (int'(s) < n) begin
               mY[d] = chanVal(d, int'(s)); mV[d] = 1; mE[d] = 0;
            end else begin
               mY[d] = 0; mV[d] = 0; mE[d] = 1;
            end
         end else begin
            mE[d] = 0;
            hit   = 1'b0;
            for (int off = 0; off < n; off++) begin
               idx = (mP[d] + off) % n;
               if (!hit && mask[idx]) begin
                  hit    = 1'b1;
                  mY[d]  = chanVal(d, idx);
                  mCh[d] = idx;
                  mV[d]  = 1;
                  mP[d]  = (idx + 1) % n;
               end
            end
            if (!hit) mV[d] = 0;
         end
      end
   endtask

   // Drive one instance for the coming edge (the other is held with EN=0)
   // and queue what its registers should show afterwards.
   task automatic applyStimulus(input int d, input logic rst, input logic en,
                                input logic mode, input logic [2:0] s,
                                input logic [7:0] mask, input string tag);
      expect_t e;
      if (d == 0) begin
         rstA = rst; busA.EN = en; busA.MODE = mode; busA.S = s; busA.MASK = mask;
         rstB = 1'b0; busB.EN = 1'b0;
      end else begin
         rstB = rst; busB.EN = en; busB.MODE = mode; busB.S = s; busB.MASK = mask[4:0];
         rstA = 1'b0; busA.EN = 1'b0;
      end
      modelStep(d, rst, en, mode, s, mask);
      e.dut   = d;
      e.y     = 16'(mY[d]);
      e.ch    = 3'(mCh[d]);
      e.valid = mV[d][0];
      e.err   = mE[d][0];
      e.tag   = tag;
      sb.push_back(e);
   endtask

   // Let the edge happen, then compare away from it.
   task automatic checkOutput();
      expect_t     e;
      logic [15:0] obsY;
      logic [2:0]  obsCh;
      logic        obsV;
      logic        obsE;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL scoreboard: got empty queue, expected an entry");
         return;
      end
      e = sb.pop_front();
      if (e.dut == 0) begin
         obsY = busA.Y; obsCh = busA.CH; obsV = busA.VALID; obsE = busA.ERR;
      end else begin
         obsY = {8'h00, busB.Y}; obsCh = busB.CH; obsV = busB.VALID; obsE = busB.ERR;
      end
      checks++;
      assert (obsY === e.y) else begin
         errors++;
         $error("[TB] FAIL %s.Y: got %h expected %h", e.tag, obsY, e.y);
      end
      checks++;
      assert (obsCh === e.ch) else begin
         errors++;
         $error("[TB] FAIL %s.CH: got %0d expected %0d", e.tag, obsCh, e.ch);
      end
      checks++;
      assert (obsV === e.valid) else begin
         errors++;
         $error("[TB] FAIL %s.VALID: got %b expected %b", e.tag, obsV, e.valid);
      end
      checks++;
      assert (obsE === e.err) else begin
         errors++;
         $error("[TB] FAIL %s.ERR: got %b expected %b", e.tag, obsE, e.err);
      end
   endtask

   task automatic step(input int d, input logic rst, input logic en,
                       input logic mode, input logic [2:0] s,
                       input logic [7:0] mask, input string tag);
      applyStimulus(d, rst, en, mode, s, mask, tag);
      checkOutput();
   endtask

   // Directed sequence following the block's test plan.
   initial begin
      chanA = '{16'h00DE, 16'h00BC, 16'h009A, 16'h0078,
                16'h0056, 16'h0034, 16'h0012, 16'h00F0};
      chanB = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int c = 0; c < 8; c++) busA.I[c*16 +: 16] = chanA[c];
      for (int c = 0; c < 5; c++) busB.I[c*8 +: 8]   = chanB[c];
      for (int d = 0; d < 2; d++) begin
         mY[d] = 0; mCh[d] = 0; mV[d] = 0; mE[d] = 0; mP[d] = 0;
      end
      rstA = 1'b0; rstB = 1'b0;
      busA.EN = 1'b0; busA.MODE = 1'b0; busA.S = '0; busA.MASK = '0;
      busB.EN = 1'b0; busB.MODE = 1'b0; busB.S = '0; busB.MASK = '0;
      $display("[TB] start");

      // Reset overrides an enabled direct select, then EN low holds zeros.
      step(0, 1'b1, 1'b1, 1'b0, 3'd3, 8'h00, "rst0");
      step(0, 1'b1, 1'b1, 1'b0, 3'd3, 8'h00, "rst1");
      step(0, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, "hold0");
      step(0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h00, "hold1");
      step(0, 1'b0, 1'b0, 1'b0, 3'd7, 8'h00, "hold2");

      // Direct sweep across all eight channels.
      for (int k = 0; k < 8; k++) step(0, 1'b0, 1'b1, 1'b0, 3'(k), 8'h00, "direct");

      // Masked scan after reset: channels 0, 2, 5, 7, then wrap to 0.
      step(0, 1'b1, 1'b1, 1'b1, 3'd0, 8'hA5, "scanRst");
      for (int k = 0; k < 5; k++) step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'hA5, "scanA5");
      step(0, 1'b0, 1'b0, 1'b1, 3'd0, 8'hFF, "scanHold0");
      step(0, 1'b0, 1'b0, 1'b1, 3'd0, 8'hFF, "scanHold1");

      // Empty mask drops VALID but keeps Y/CH; single bit then repeats.
      step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, "empty0");
      step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, "empty1");
      step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h40, "single0");
      step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h40, "single1");

      // Direct then back to scan: scan resumes from the retained pointer.
      step(0, 1'b0, 1'b1, 1'b0, 3'd1, 8'hFF, "modeDir");
      step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'hFF, "modeScan");

      // Reset mid-scan discards progress.
      step(0, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF, "midRst0");
      for (int k = 0; k < 4; k++) step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'hFF, "midScan");
      step(0, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF, "midRst1");
      step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'hFF, "midResume");

      // Five-channel instance: out-of-range selects and exact wrap 4 -> 0.
      step(1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, "oddRst");
      step(1, 1'b0, 1'b1, 1'b0, 3'd5, 8'h00, "oddS5");
      step(1, 1'b0, 1'b1, 1'b0, 3'd4, 8'h00, "oddS4");
      step(1, 1'b0, 1'b1, 1'b0, 3'd7, 8'h00, "oddS7");
      for (int k = 0; k < 6; k++) step(1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h1F, "oddScan");
      step(1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h11, "oddMask");
      step(1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h11, "oddMaskWrap");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_nto1_reg_scan.md
Name: mux_nto1_reg_scan

Overview:
- Parametrised, registered N-to-1 datapath multiplexer with a clock enable.
- Two modes:
  - Direct select: the S port chooses the channel.
  - Round-robin scan: the block walks through the channels enabled in MASK, one per enabled cycle.
- Used in the single-cycle RISC datapath wherever a wide, timing-clean selected source is needed (writeback source, debug register readout).
- Adds to the plain combinational 8:1 16-bit mux: arbitrary channel count and width, an output register, out-of-range select detection, and autonomous masked scanning.

Parameters:
- WIDTH, 16, data width per channel.
- NUM_IN, 8, number of input channels; NUM_IN >= 2, need not be a power of two.
- SEL_W, 3, select/channel-index width; must equal ceil(log2(NUM_IN)).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous active-high reset.
- I  input  NUM_IN*WIDTH  packed channels; channel k at I[k*WIDTH +: WIDTH].
- S  input  SEL_W  channel select, used in direct mode.
- MODE  input  1  0 = direct, 1 = scan.
- EN  input  1  update enable; when low, all state holds.
- MASK  input  NUM_IN  scan-eligible channels, used in scan mode only.
- Y  output  WIDTH  registered selected data.
- CH  output  SEL_W  index of the channel currently held in Y.
- VALID  output  1  Y holds legitimately selected data.
- ERR  output  1  last direct select was out of range.

Behaviour:
- Reset:
  - On any rising edge with RST=1: Y=0, CH=0, VALID=0, ERR=0, scan pointer P=0.
  - RST overrides EN and MODE.
  - Mid-scan reset discards scan progress.
- Latency:
  - All outputs are registered, with one cycle of latency from sampled inputs to outputs.
  - No combinational path from any input to any output.
- EN=0 (and RST=0): Y, CH, VALID, ERR and P all hold; I, S and MASK are ignored.
- Direct mode (MODE=0, EN=1):
  - If S < NUM_IN: Y <= channel S, CH <= S, VALID <= 1, ERR <= 0.
  - If S >= NUM_IN: Y <= 0, CH <= S, VALID <= 0, ERR <= 1.
  - MASK is ignored and P is unchanged.
- Scan mode (MODE=1, EN=1):
  - Search order: P, P+1, ..., P+NUM_IN-1, all modulo NUM_IN; k = first index in that order with MASK[k]=1.
  - If k exists: Y <= channel k, CH <= k, VALID <= 1, ERR <= 0, P <= (k+1) mod NUM_IN.
  - If MASK=0: Y, CH and P hold; VALID <= 0; ERR <= 0.
  - A single set mask bit gives the same channel every cycle.
  - MASK changes take effect on the next enabled edge.
- Wrap-around:
  - P and k wrap from NUM_IN-1 to 0 exactly; no stray indices when NUM_IN is not a power of two.
- Mode switching:
  - MODE is sampled on each edge, with no settling cycle.
  - Entering scan mode resumes from the retained P.
- Implementation:
  - Priority search as a combinational rotate plus priority encoder over NUM_IN bits.
  - All state in a single always block on posedge CLK.

Test Plan:
1. Reset and hold:
   - Stimulus: RST=1 for 2 cycles with EN=1, MODE=0, S=3; then RST=0, EN=0 for 3 cycles while S changes.
   - Response: Y=0000, CH=0, VALID=0, ERR=0 throughout.
2. Direct sweep (defaults; I0..I7 = 00DE, 00BC, 009A, 0078, 0056, 0034, 0012, 00F0):
   - Stimulus: EN=1, MODE=0, S=0..7, one value per cycle.
   - Response: one cycle later Y = 00DE, 00BC, 009A, 0078, 0056, 0034, 0012, 00F0; CH tracks S; VALID=1.
3. Masked scan with wrap:
   - Stimulus: MODE=1, MASK=8'b1010_0101, after reset.
   - Response: successive Y = 00DE, 009A, 0034, 00F0, 00DE; CH = 0, 2, 5, 7, 0.
   - Then pull EN low for 2 cycles: Y and CH hold.
4. Empty mask and recovery:
   - Stimulus: in scan, MASK=0 for 2 cycles.
   - Response: VALID=0, Y unchanged. Then MASK=8'h40 gives Y=0012, CH=6, VALID=1 on the next two edges.
5. Odd channel count (WIDTH=8, NUM_IN=5, SEL_W=3; channels 11, 22, 33, 44, 55):
   - Direct S=5: Y=00, VALID=0, ERR=1. Then S=4: Y=55, ERR=0.
   - Scan with MASK=5'b11111: Y = 11, 22, 33, 44, 55, 11 (wraps 4 to 0).
6. Reset mid-scan:
   - Stimulus: in scan, MASK=8'hFF, CH=3; assert RST for 1 cycle.
   - Response: Y=0, VALID=0, CH=0. The next enabled scan edge gives Y=00DE, CH=0.
